fmc_arbiter: RTL and testbench
==============================

FMC_ARBITER -- requirements
Module: fmc_arbiter

Interface
REQ-001 Parameter pAddrWidth, default 27, flash byte-address width.
REQ-002 Parameter pBurstMax, default 256, max byte strobes per grant before forced release.
REQ-003 Parameter pStarve, default 4, consecutive sound grants allowed while pixel pending.
REQ-004 iSysClk  input  1  system clock; only clock, all logic on rising edge.
REQ-005 iRst  input  1  reset, asynchronous, active-high.
REQ-006 iReq[2:0]  input  3  request per requester: bit0 update (USB), bit1 sound, bit2 pixel; held high for the whole burst.
REQ-007 iAddr0/iAddr1/iAddr2  input  pAddrWidth each  requester byte address.
REQ-008 iCmd[2:0]  input  3  per-requester command, 1 write, 0 read.
REQ-009 iWd0/iWd1/iWd2  input  8 each  per-requester write byte.
REQ-010 iCke[2:0]  input  3  per-requester byte strobe.
REQ-011 oGnt[2:0]  output  3  one-hot grant, registered.
REQ-012 oFmcAddr  output  pAddrWidth  address forwarded to flash controller.
REQ-013 oFmcCmd  output  1  command forwarded.
REQ-014 oFmcWd  output  8  write byte forwarded.
REQ-015 oFmcCke  output  1  byte strobe forwarded.
REQ-016 iFmcBusy  input  1  flash controller has a transaction in flight.
REQ-017 iFmcRd  input  8  read byte from flash controller.
REQ-018 iFmcRdVd / iFmcWdVd  input  1 each  read-data valid / write-accepted pulses.
REQ-019 oRdVd[2:0] / oWdVd[2:0]  output  3 each  valid pulses routed to granted requester only.
REQ-020 oRd  output  8  iFmcRd broadcast to all requesters.

Function
REQ-021 State machine SHALL have states IDLE, GRANT, DRAIN.
REQ-022 IDLE: if any iReq set, select winner, register one-hot oGnt, go GRANT next cycle (grant latency 1 cycle); else stay.
REQ-023 Priority: update > sound > pixel, except pixel wins over sound when starvation counter equals pStarve.
REQ-024 Starvation counter increments on each sound grant issued while iReq[2]=1, clears on pixel grant or when iReq[2]=0, saturates at pStarve.
REQ-025 GRANT: oFmcAddr/Cmd/Wd/Cke SHALL be a combinational mux of the granted requester's inputs; with no grant all forwarded outputs are 0.
REQ-026 Burst counter (width clog2(pBurstMax)+1) clears on entering GRANT, increments on each forwarded oFmcCke.
REQ-027 GRANT -> DRAIN when granted iReq falls, or when burst count reaches pBurstMax and granted requester is not update.
REQ-028 Update requester is never force-released; burst limit ignored for bit0.
REQ-029 When burst count equals pBurstMax, oFmcCke SHALL be gated to 0 even if iCke is high.
REQ-030 DRAIN: oGnt cleared on entry, forwarded outputs 0; valid-pulse routing retained to the last owner; go IDLE when iFmcBusy=0.
REQ-031 oRdVd/oWdVd SHALL be iFmcRdVd/iFmcWdVd ANDed with current owner one-hot (owner held through DRAIN).
REQ-032 iReq rising for a non-granted requester during GRANT/DRAIN SHALL be held pending, not preempt.
REQ-033 Simultaneous release and new request: minimum one IDLE cycle between grants.
REQ-034 iCke from non-granted requesters SHALL be ignored.

Reset
REQ-035 On iRst high, immediately: state IDLE, oGnt=0, owner=0, burst and starvation counters 0, all forwarded and valid outputs 0.
REQ-036 Reset mid-burst SHALL abort without waiting for iFmcBusy; after release, arbitration resumes from IDLE on first clock.

Verification
REQ-037 iReq=3'b110 in IDLE -> oGnt=3'b010 next cycle; sound iAddr1=0x100, iCke pulse -> oFmcAddr=0x100, oFmcCke=1 same cycle.
REQ-038 pBurstMax=4, sound holds iReq, 5 iCke strobes -> 4 oFmcCke, 5th gated, oGnt drops, DRAIN until iFmcBusy=0.
REQ-039 pStarve=4, sound and pixel both requesting continuously -> grant order sound x4, pixel, sound x4, pixel.
REQ-040 Update requests during pixel grant -> pixel keeps grant until release; after DRAIN and one IDLE, oGnt=3'b001; update burst of 300 bytes not cut.
REQ-041 iFmcRdVd pulse with iFmcRd=0xA5 during pixel grant -> oRdVd=3'b100, oRd=0xA5; other bits 0.
REQ-042 iRst asserted mid-burst with iFmcBusy=1 -> oGnt=0, oFmcCke=0 without waiting for a clock edge; after release new request granted after 1 cycle.

Source files
------------

// File: rtl/fmc_arbiter.sv
// Three-way arbiter in front of the flash memory controller: update (USB), sound and pixel
// requesters share one byte-wide flash port, with burst limiting and pixel anti-starvation.
module fmc_arbiter #(
  parameter int pAddrWidth = 27,
  parameter int pBurstMax  = 256,
  parameter int pStarve    = 4
) (
  input  logic                  iSysClk,
  input  logic                  iRst,
  input  logic [2:0]            iReq,
  input  logic [pAddrWidth-1:0] iAddr0,
  input  logic [pAddrWidth-1:0] iAddr1,
  input  logic [pAddrWidth-1:0] iAddr2,
  input  logic [2:0]            iCmd,
  input  logic [7:0]            iWd0,
  input  logic [7:0]            iWd1,
  input  logic [7:0]            iWd2,
  input  logic [2:0]            iCke,
  output logic [2:0]            oGnt,
  output logic [pAddrWidth-1:0] oFmcAddr,
  output logic                  oFmcCmd,
  output logic [7:0]            oFmcWd,
  output logic                  oFmcCke,
  input  logic                  iFmcBusy,
  input  logic [7:0]            iFmcRd,
  input  logic                  iFmcRdVd,
  input  logic                  iFmcWdVd,
  output logic [2:0]            oRdVd,
  output logic [2:0]            oWdVd,
  output logic [7:0]            oRd,
  output logic [1:0]            oState
);

  localparam int cBurstW  = $clog2(pBurstMax) + 1;
  localparam int cStarveW = $clog2(pStarve + 1);
  localparam logic [cBurstW-1:0]  cBurstMax  = cBurstW'(pBurstMax);
  localparam logic [cStarveW-1:0] cStarveMax = cStarveW'(pStarve);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               stateQ, stateNext;
  logic [2:0]           gntQ, gntNext;
  logic [2:0]           ownerQ, ownerNext;
  logic [cBurstW-1:0]   burstQ, burstNext;
  logic [cStarveW-1:0]  starveQ, starveNext;
  logic [2:0]           winner;
  logic                 selCke;
  logic                 atLimit;
  logic                 reqHeld;

  // Handshake: a requester owns the port from oGnt rising until it drops iReq (or is
  // force-released); every iCke high while granted and not gated is one byte transferred.
  always_ff @(posedge iSysClk or posedge iRst) begin
    if (iRst) begin
      stateQ  <= IDLE;
      gntQ    <= '0;
      ownerQ  <= '0;
      burstQ  <= '0;
      starveQ <= '0;
    end else begin
      stateQ  <= stateNext;
      gntQ    <= gntNext;
      ownerQ  <= ownerNext;
      burstQ  <= burstNext;
      starveQ <= starveNext;
    end
  end

  // Pixel jumps ahead of sound only once sound has been served pStarve times in a row.
  always_comb begin
    winner = 3'b000;
    if (iReq[0])                                        winner = 3'b001;
    else if (iReq[2] && (!iReq[1] || starveQ == cStarveMax)) winner = 3'b100;
    else if (iReq[1])                                   winner = 3'b010;
  end

  always_comb begin
    oFmcAddr = '0;
    oFmcCmd  = 1'b0;
    oFmcWd   = '0;
    selCke   = 1'b0;
    if (gntQ[0]) begin
      oFmcAddr = iAddr0; oFmcCmd = iCmd[0]; oFmcWd = iWd0; selCke = iCke[0];
    end else if (gntQ[1]) begin
      oFmcAddr = iAddr1; oFmcCmd = iCmd[1]; oFmcWd = iWd1; selCke = iCke[1];
    end else if (gntQ[2]) begin
      oFmcAddr = iAddr2; oFmcCmd = iCmd[2]; oFmcWd = iWd2; selCke = iCke[2];
    end
  end

  assign atLimit = (burstQ == cBurstMax);
  assign reqHeld = |(iReq & gntQ);
  // Update traffic is never limited, so its strobes pass even with a saturated count.
  assign oFmcCke = selCke && !(atLimit && !gntQ[0]);

  always_comb begin
    stateNext  = stateQ;
    gntNext    = gntQ;
    ownerNext  = ownerQ;
    burstNext  = burstQ;
    starveNext = starveQ;
    case (stateQ)
      IDLE: begin
        if (|iReq) begin
          stateNext = GRANT;
          gntNext   = winner;
          ownerNext = winner;
          burstNext = '0;
          if (winner[2])
            starveNext = '0;
          else if (winner[1] && iReq[2] && starveQ != cStarveMax)
            starveNext = starveQ + 1'b1;
        end
      end
      GRANT: begin
        if (oFmcCke && !atLimit)
          burstNext = burstQ + 1'b1;
        if (!reqHeld || (atLimit && !gntQ[0])) begin
          stateNext = DRAIN;
          gntNext   = '0;
        end
      end
      DRAIN: begin
        if (!iFmcBusy) begin
          stateNext = IDLE;
          ownerNext = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        gntNext   = '0;
        ownerNext = '0;
      end
    endcase
    if (!iReq[2])
      starveNext = '0;
  end

  assign oGnt   = gntQ;
  assign oRdVd  = {3{iFmcRdVd}} & ownerQ;
  assign oWdVd  = {3{iFmcWdVd}} & ownerQ;
  assign oRd    = iFmcRd;
  assign oState = stateQ;

endmodule

// File: tb/tb_fmc_arbiter.sv
// Bench for fmc_arbiter: scenario tasks plus randomized forwarding checked against
// a behavioural model of grant ownership and per-burst strobe budget.
module tb_fmc_arbiter;

  localparam int AW = 27;
  localparam int BM = 4;
  localparam int ST = 4;

  logic          iSysClk = 1'b0;
  logic          iRst;
  logic [2:0]    iReq, iCmd, iCke;
  logic [AW-1:0] a [3];
  logic [7:0]    w [3];
  logic          iFmcBusy, iFmcRdVd, iFmcWdVd;
  logic [7:0]    iFmcRd;
  logic [2:0]    oGnt, oRdVd, oWdVd;
  logic [AW-1:0] oFmcAddr;
  logic          oFmcCmd, oFmcCke;
  logic [7:0]    oFmcWd, oRd;
  logic [1:0]    oState;

  int total = 0;
  int bad   = 0;

  always #5 iSysClk = ~iSysClk;

  fmc_arbiter #(.pAddrWidth(AW), .pBurstMax(BM), .pStarve(ST)) dut (
    .iSysClk(iSysClk), .iRst(iRst), .iReq(iReq),
    .iAddr0(a[0]), .iAddr1(a[1]), .iAddr2(a[2]),
    .iCmd(iCmd), .iWd0(w[0]), .iWd1(w[1]), .iWd2(w[2]), .iCke(iCke),
    .oGnt(oGnt), .oFmcAddr(oFmcAddr), .oFmcCmd(oFmcCmd), .oFmcWd(oFmcWd), .oFmcCke(oFmcCke),
    .iFmcBusy(iFmcBusy), .iFmcRd(iFmcRd), .iFmcRdVd(iFmcRdVd), .iFmcWdVd(iFmcWdVd),
    .oRdVd(oRdVd), .oWdVd(oWdVd), .oRd(oRd), .oState(oState)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge iSysClk);
    #1;
  endtask

  task automatic quiet_inputs;
    iReq = 3'b000; iCke = 3'b000; iCmd = 3'b000;
    iFmcBusy = 1'b0; iFmcRdVd = 1'b0; iFmcWdVd = 1'b0; iFmcRd = 8'h00;
    for (int i = 0; i < 3; i++) begin a[i] = '0; w[i] = '0; end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (oState !== 2'd0 && n < 30) begin tick; n++; end
    #2;
    total++;
    if (oState !== 2'd0) begin bad++; $display("FAIL %s idle_timeout: state=%0d want 0", name, oState); end
    tick;
  endtask

  task automatic test_reset;
    quiet_inputs();
    iRst = 1'b1; iFmcRdVd = 1'b1; iFmcWdVd = 1'b1; iReq = 3'b111; iCke = 3'b111;
    #3;
    total++; if (oGnt !== 3'b000)   begin bad++; $display("FAIL reset_gnt: got=%b want=000", oGnt); end
    total++; if (oFmcCke !== 1'b0)  begin bad++; $display("FAIL reset_cke: got=%b want=0", oFmcCke); end
    total++; if (oFmcAddr !== '0)   begin bad++; $display("FAIL reset_addr: got=%h want=0", oFmcAddr); end
    total++; if (oRdVd !== 3'b000 || oWdVd !== 3'b000) begin bad++; $display("FAIL reset_vd: rd=%b wd=%b want 000", oRdVd, oWdVd); end
    total++; if (oState !== 2'd0)   begin bad++; $display("FAIL reset_state: got=%0d want=0", oState); end
    quiet_inputs();
    tick; iRst = 1'b0; tick;
  endtask

  task automatic test_basic;
    a[1] = 27'h100; w[1] = 8'h3C; iCmd = 3'b010; iReq = 3'b110;
    tick; #2;
    total++; if (oGnt !== 3'b010) begin bad++; $display("FAIL basic_gnt: got=%b want=010", oGnt); end
    iCke = 3'b110; #1;
    total++; if (oFmcAddr !== 27'h100) begin bad++; $display("FAIL basic_addr: got=%h want=100", oFmcAddr); end
    total++; if (oFmcCke !== 1'b1 || oFmcCmd !== 1'b1 || oFmcWd !== 8'h3C)
      begin bad++; $display("FAIL basic_fwd: cke=%b cmd=%b wd=%h want 1 1 3c", oFmcCke, oFmcCmd, oFmcWd); end
    tick; iCke = 3'b000; iReq = 3'b000;
    wait_idle("basic");
    quiet_inputs();
  endtask

  task automatic test_random_fwd;
    for (int it = 0; it < 12; it++) begin
      int r = $urandom_range(0, 2);
      bit granted = 1'b1;
      int cnt = 0;
      logic [2:0] own = 3'(1 << r);
      iFmcBusy = 1'b1; iReq = own;
      tick; #2;
      total++; if (oGnt !== own) begin bad++; $display("FAIL rnd_gnt: got=%b want=%b", oGnt, own); end
      for (int c = 0; c < 7; c++) begin
        logic [AW-1:0] eAddr; logic [7:0] eWd; logic eCmd, eCke; logic [2:0] eGnt;
        iCke = 3'($urandom_range(0, 7)); iCmd = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) begin a[i] = AW'($urandom); w[i] = 8'($urandom); end
        iFmcRdVd = 1'($urandom_range(0, 1)); iFmcWdVd = 1'($urandom_range(0, 1)); iFmcRd = 8'($urandom);
        #2;
        eAddr = granted ? a[r] : '0;
        eWd   = granted ? w[r] : 8'h00;
        eCmd  = granted ? iCmd[r] : 1'b0;
        eCke  = granted && iCke[r] && (r == 0 || cnt < BM);
        eGnt  = granted ? own : 3'b000;
        total++; if (oGnt !== eGnt) begin bad++; $display("FAIL rnd_hold_gnt: got=%b want=%b", oGnt, eGnt); end
        total++; if (oFmcAddr !== eAddr || oFmcWd !== eWd || oFmcCmd !== eCmd)
          begin bad++; $display("FAIL rnd_mux: got=%h/%h/%b want=%h/%h/%b", oFmcAddr, oFmcWd, oFmcCmd, eAddr, eWd, eCmd); end
        total++; if (oFmcCke !== eCke) begin bad++; $display("FAIL rnd_cke: got=%b want=%b", oFmcCke, eCke); end
        total++; if (oRdVd !== (iFmcRdVd ? own : 3'b000) || oWdVd !== (iFmcWdVd ? own : 3'b000) || oRd !== iFmcRd)
          begin bad++; $display("FAIL rnd_vd: rd=%b wd=%b rdata=%h", oRdVd, oWdVd, oRd); end
        if (granted && r != 0 && cnt == BM) granted = 1'b0;
        if (eCke) cnt++;
        tick;
      end
      iReq = 3'b000; iCke = 3'b000; iFmcBusy = 1'b0; iFmcRdVd = 1'b0; iFmcWdVd = 1'b0;
      wait_idle("rnd");
    end
    quiet_inputs();
  endtask

  task automatic test_burst_limit;
    int fwd = 0;
    iReq = 3'b010; iFmcBusy = 1'b1;
    tick;
    for (int c = 0; c < 5; c++) begin
      iCke = 3'b010; #2;
      if (oFmcCke === 1'b1) fwd++;
      tick;
    end
    #2;
    total++; if (fwd !== BM) begin bad++; $display("FAIL burst_count: got=%0d want=%0d", fwd, BM); end
    total++; if (oGnt !== 3'b000) begin bad++; $display("FAIL burst_release: got=%b want=000", oGnt); end
    tick; tick; #2;
    total++; if (oState !== 2'd2) begin bad++; $display("FAIL burst_drain_hold: state=%0d want=2", oState); end
    iFmcBusy = 1'b0; iReq = 3'b000; iCke = 3'b000;
    wait_idle("burst");
  endtask

  task automatic test_starvation;
    logic [2:0] seen [10];
    logic [2:0] prev = 3'b000;
    int n = 0, cyc = 0, s = 0;
    iReq = 3'b110; iCke = 3'b110; iFmcBusy = 1'b0;
    while (n < 10 && cyc < 300) begin
      tick; #2;
      if (oGnt !== 3'b000 && prev === 3'b000) begin seen[n] = oGnt; n++; end
      prev = oGnt; cyc++;
    end
    total++; if (n != 10) begin bad++; $display("FAIL starve_grants: got=%0d want=10", n); end
    for (int i = 0; i < n; i++) begin
      logic [2:0] e;
      if (s == ST) begin e = 3'b100; s = 0; end
      else begin e = 3'b010; s = (s < ST) ? s + 1 : s; end
      total++; if (seen[i] !== e) begin bad++; $display("FAIL starve_order[%0d]: got=%b want=%b", i, seen[i], e); end
    end
    iReq = 3'b000; iCke = 3'b000;
    wait_idle("starve");
  endtask

  task automatic test_update_hold;
    int fwd = 0;
    bit held = 1'b1;
    iReq = 3'b100; iFmcBusy = 1'b1;
    tick; #2;
    total++; if (oGnt !== 3'b100) begin bad++; $display("FAIL upd_pix_gnt: got=%b want=100", oGnt); end
    iReq = 3'b101;
    for (int c = 0; c < 5; c++) begin
      tick; #2;
      total++; if (oGnt !== 3'b100) begin bad++; $display("FAIL upd_no_preempt: got=%b want=100", oGnt); end
    end
    iReq = 3'b001;
    tick; #2;
    total++; if (oGnt !== 3'b000 || oState !== 2'd2) begin bad++; $display("FAIL upd_drain: gnt=%b state=%0d want 000/2", oGnt, oState); end
    tick; #2;
    total++; if (oGnt !== 3'b000) begin bad++; $display("FAIL upd_drain_busy: got=%b want=000", oGnt); end
    iFmcBusy = 1'b0;
    tick; #2;
    total++; if (oGnt !== 3'b000 || oState !== 2'd0) begin bad++; $display("FAIL upd_idle_gap: gnt=%b state=%0d want 000/0", oGnt, oState); end
    tick; #2;
    total++; if (oGnt !== 3'b001) begin bad++; $display("FAIL upd_gnt: got=%b want=001", oGnt); end
    for (int c = 0; c < 300; c++) begin
      iCke = {2'($urandom_range(0, 3)), 1'b1}; #1;
      if (oFmcCke === 1'b1) fwd++;
      if (oGnt !== 3'b001) held = 1'b0;
      tick;
    end
    total++; if (fwd != 300) begin bad++; $display("FAIL upd_burst: got=%0d want=300", fwd); end
    total++; if (!held) begin bad++; $display("FAIL upd_cut: grant lost during long update burst"); end
    iReq = 3'b000; iCke = 3'b000;
    wait_idle("upd");
  endtask

  task automatic test_rd_route;
    iReq = 3'b100; iFmcBusy = 1'b1;
    tick;
    iFmcRd = 8'hA5; iFmcRdVd = 1'b1; #2;
    total++; if (oRdVd !== 3'b100 || oRd !== 8'hA5 || oWdVd !== 3'b000)
      begin bad++; $display("FAIL rd_route: rdvd=%b rd=%h wdvd=%b want 100 a5 000", oRdVd, oRd, oWdVd); end
    iFmcRdVd = 1'b0; iFmcWdVd = 1'b1; #1;
    total++; if (oWdVd !== 3'b100 || oRdVd !== 3'b000) begin bad++; $display("FAIL wd_route: wdvd=%b rdvd=%b want 100 000", oWdVd, oRdVd); end
    iFmcWdVd = 1'b0; iReq = 3'b000;
    tick; iFmcRdVd = 1'b1; #2;
    total++; if (oRdVd !== 3'b100 || oGnt !== 3'b000) begin bad++; $display("FAIL rd_drain_route: rdvd=%b gnt=%b want 100 000", oRdVd, oGnt); end
    iFmcRdVd = 1'b0; iFmcBusy = 1'b0;
    wait_idle("rd");
    iFmcRdVd = 1'b1; #1;
    total++; if (oRdVd !== 3'b000) begin bad++; $display("FAIL rd_idle_route: got=%b want=000", oRdVd); end
    quiet_inputs();
  endtask

  task automatic test_reset_mid;
    iReq = 3'b010; iCke = 3'b010; iFmcBusy = 1'b1;
    tick; #2;
    total++; if (oGnt !== 3'b010 || oFmcCke !== 1'b1) begin bad++; $display("FAIL rstmid_pre: gnt=%b cke=%b want 010 1", oGnt, oFmcCke); end
    #1; iRst = 1'b1; #1;
    total++; if (oGnt !== 3'b000 || oFmcCke !== 1'b0) begin bad++; $display("FAIL rstmid_async: gnt=%b cke=%b want 000 0", oGnt, oFmcCke); end
    total++; if (oState !== 2'd0) begin bad++; $display("FAIL rstmid_state: got=%0d want=0", oState); end
    #2; iRst = 1'b0;
    tick; #2;
    total++; if (oGnt !== 3'b010) begin bad++; $display("FAIL rstmid_regrant: got=%b want=010", oGnt); end
    iReq = 3'b000; iCke = 3'b000; iFmcBusy = 1'b0;
    wait_idle("rstmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_fwd();
    test_burst_limit();
    test_starvation();
    test_update_hold();
    test_rd_route();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
